// File: rtl/ysyx_22050710_bpu_pkg.sv
// Shared definitions for the branch prediction unit: 2-bit counter encodings,
// allocation policy and PC index/tag slice helpers.
package ysyx_22050710_bpu_pkg;

    localparam logic [1:0] CTR_SNT   = 2'b00;
    localparam logic [1:0] CTR_WNT   = 2'b01;
    localparam logic [1:0] CTR_WT    = 2'b10;
    localparam logic [1:0] CTR_ST    = 2'b11;
    localparam logic [1:0] ALLOC_BR  = CTR_WT;
    localparam logic [1:0] ALLOC_JMP = CTR_ST;

    // Index field sits just above the always-zero halfword/byte offset bits.
    function automatic logic [63:0] bpu_idx(input logic [63:0] pc, input int idx_wd);
        return (pc >> 2) & ((64'd1 << idx_wd) - 64'd1);
    endfunction

    function automatic logic [63:0] bpu_tag(input logic [63:0] pc, input int idx_wd,
                                            input int tag_wd);
        return (pc >> (idx_wd + 2)) & ((64'd1 << tag_wd) - 64'd1);
    endfunction

endpackage

// File: rtl/ysyx_22050710_sat_ctr2.sv
// Combinational next-state of a 2-bit saturating direction counter;
// i_force_st pins the counter to strongly-taken for unconditional jumps.
module ysyx_22050710_sat_ctr2
    import ysyx_22050710_bpu_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_inc,
    input  logic       i_force_st,
    output logic [1:0] o_ctr
);

    // Saturating increment/decrement with jump override
    always_comb begin
        o_ctr = i_ctr;
        if (i_force_st) begin
            o_ctr = CTR_ST;
        end else if (i_inc) begin
            case (i_ctr)
                CTR_SNT: o_ctr = CTR_WNT;
                CTR_WNT: o_ctr = CTR_WT;
                CTR_WT:  o_ctr = CTR_ST;
                default: o_ctr = CTR_ST;
            endcase
        end else begin
            case (i_ctr)
                CTR_ST:  o_ctr = CTR_WT;
                CTR_WT:  o_ctr = CTR_WNT;
                CTR_WNT: o_ctr = CTR_SNT;
                default: o_ctr = CTR_SNT;
            endcase
        end
    end

endmodule

// File: rtl/ysyx_22050710_bpu.sv
// Direct-mapped BTB with 2-bit counters; registered 1-cycle next-PC prediction.
// Optional statistics counters enabled by YSYX_22050710_BPU_STATS_EN.
module ysyx_22050710_bpu
    import ysyx_22050710_bpu_pkg::*;
#(
    parameter int PC_WD  = 64,
    parameter int DEPTH  = 16,
    parameter int TAG_WD = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pred_valid,
    input  logic [PC_WD-1:0] i_pred_pc,
    input  logic             i_stall,
    input  logic             i_flush,
    output logic             o_pred_valid,
    output logic             o_pred_taken,
    output logic [PC_WD-1:0] o_pred_npc,
    input  logic             i_upd_valid,
    input  logic [PC_WD-1:0] i_upd_pc,
    input  logic             i_upd_jump,
    input  logic             i_upd_taken,
    input  logic [PC_WD-1:0] i_upd_target,
`ifdef YSYX_22050710_BPU_STATS_EN
    output logic [31:0]      o_stat_lookup,
    output logic [31:0]      o_stat_hit,
    output logic [31:0]      o_stat_upd,
    output logic [31:0]      o_stat_mispred,
`endif
    input  logic             i_upd_mispred
);

    localparam int IDX_WD = $clog2(DEPTH);

    logic              valid_r  [DEPTH];
    logic [TAG_WD-1:0] tag_r    [DEPTH];
    logic [1:0]        ctr_r    [DEPTH];
    logic [PC_WD-1:0]  target_r [DEPTH];

    logic [IDX_WD-1:0] pred_idx_s, upd_idx_s;
    logic [TAG_WD-1:0] pred_tag_s, upd_tag_s;
    logic              pred_hit_s, pred_taken_s, upd_hit_s;
    logic [PC_WD-1:0]  pred_npc_s;
    logic [1:0]        ctr_next_s;

    assign pred_idx_s = IDX_WD'(bpu_idx(64'(i_pred_pc), IDX_WD));
    assign pred_tag_s = TAG_WD'(bpu_tag(64'(i_pred_pc), IDX_WD, TAG_WD));
    assign upd_idx_s  = IDX_WD'(bpu_idx(64'(i_upd_pc), IDX_WD));
    assign upd_tag_s  = TAG_WD'(bpu_tag(64'(i_upd_pc), IDX_WD, TAG_WD));

    // Lookup reads the table before this cycle's update lands (read-before-write)
    always_comb begin
        pred_hit_s   = valid_r[pred_idx_s] && (tag_r[pred_idx_s] == pred_tag_s);
        pred_taken_s = pred_hit_s && ctr_r[pred_idx_s][1];
        if (pred_taken_s) begin
            pred_npc_s = target_r[pred_idx_s];
        end else begin
            pred_npc_s = i_pred_pc + PC_WD'(64'd4);
        end
        upd_hit_s = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
    end

    ysyx_22050710_sat_ctr2 u_sat_ctr2 (
        .i_ctr      (ctr_r[upd_idx_s]),
        .i_inc      (i_upd_taken),
        .i_force_st (i_upd_jump),
        .o_ctr      (ctr_next_s)
    );

    // Prediction output register bank
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_pred_valid <= 1'b0;
            o_pred_taken <= 1'b0;
            o_pred_npc   <= '0;
        end else if (i_flush) begin
            o_pred_valid <= 1'b0;
        end else if (i_stall) begin
            o_pred_valid <= o_pred_valid;
        end else if (i_pred_valid) begin
            o_pred_valid <= 1'b1;
            o_pred_taken <= pred_taken_s;
            o_pred_npc   <= pred_npc_s;
        end else begin
            o_pred_valid <= 1'b0;
        end
    end

    // BTB training: refresh on hit, allocate on taken/jump miss
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= '0;
                ctr_r[i]    <= CTR_SNT;
                target_r[i] <= '0;
            end
        end else if (i_upd_valid) begin
            if (upd_hit_s) begin
                target_r[upd_idx_s] <= i_upd_target;
                ctr_r[upd_idx_s]    <= ctr_next_s;
            end else if (i_upd_taken || i_upd_jump) begin
                valid_r[upd_idx_s]  <= 1'b1;
                tag_r[upd_idx_s]    <= upd_tag_s;
                target_r[upd_idx_s] <= i_upd_target;
                ctr_r[upd_idx_s]    <= i_upd_jump ? ALLOC_JMP : ALLOC_BR;
            end else begin
                valid_r[upd_idx_s] <= valid_r[upd_idx_s];
            end
        end else begin
            valid_r[upd_idx_s] <= valid_r[upd_idx_s];
        end
    end

`ifdef YSYX_22050710_BPU_STATS_EN
    logic [31:0] stat_lookup_r, stat_hit_r, stat_upd_r, stat_mispred_r;

    // Free-running event counters, wrapping at 2^32
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stat_lookup_r  <= 32'd0;
            stat_hit_r     <= 32'd0;
            stat_upd_r     <= 32'd0;
            stat_mispred_r <= 32'd0;
        end else begin
            if (i_pred_valid && !i_stall) begin
                stat_lookup_r <= stat_lookup_r + 32'd1;
            end
            if (i_pred_valid && !i_stall && pred_hit_s) begin
                stat_hit_r <= stat_hit_r + 32'd1;
            end
            if (i_upd_valid) begin
                stat_upd_r <= stat_upd_r + 32'd1;
            end
            if (i_upd_valid && i_upd_mispred) begin
                stat_mispred_r <= stat_mispred_r + 32'd1;
            end
        end
    end

    assign o_stat_lookup  = stat_lookup_r;
    assign o_stat_hit     = stat_hit_r;
    assign o_stat_upd     = stat_upd_r;
    assign o_stat_mispred = stat_mispred_r;
`else
    logic unused_s;
    assign unused_s = i_upd_mispred;
`endif

endmodule

// File: tb/tb_ysyx_22050710_bpu.sv
// Directed self-checking bench for ysyx_22050710_bpu (default DEPTH=16, PC_WD=64);
// statistics checks are compiled in with YSYX_22050710_BPU_STATS_EN.
module tb_ysyx_22050710_bpu;

    logic        clk = 1'b0;
    logic        rst_n, pred_valid, stall, flush;
    logic [63:0] pred_pc, upd_pc, upd_target, pred_npc;
    logic        pred_valid_o, pred_taken;
    logic        upd_valid, upd_jump, upd_taken, upd_mispred;
`ifdef YSYX_22050710_BPU_STATS_EN
    logic [31:0] stat_lookup, stat_hit, stat_upd, stat_mispred;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    ysyx_22050710_bpu dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_pred_valid  (pred_valid),
        .i_pred_pc     (pred_pc),
        .i_stall       (stall),
        .i_flush       (flush),
        .o_pred_valid  (pred_valid_o),
        .o_pred_taken  (pred_taken),
        .o_pred_npc    (pred_npc),
        .i_upd_valid   (upd_valid),
        .i_upd_pc      (upd_pc),
        .i_upd_jump    (upd_jump),
        .i_upd_taken   (upd_taken),
        .i_upd_target  (upd_target),
`ifdef YSYX_22050710_BPU_STATS_EN
        .o_stat_lookup (stat_lookup),
        .o_stat_hit    (stat_hit),
        .o_stat_upd    (stat_upd),
        .o_stat_mispred(stat_mispred),
`endif
        .i_upd_mispred (upd_mispred)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [63:0] pc);
        pred_valid = 1'b1;
        pred_pc    = pc;
        tick();
        pred_valid = 1'b0;
    endtask

    task automatic update(input logic [63:0] pc, input logic jump, input logic taken,
                          input logic [63:0] target);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_jump   = jump;
        upd_taken  = taken;
        upd_target = target;
        tick();
        upd_valid  = 1'b0;
    endtask

    task automatic expect_pred(input string tag, input logic taken, input logic [63:0] npc);
        check({tag, "_valid"}, {63'd0, pred_valid_o}, 64'd1);
        check({tag, "_taken"}, {63'd0, pred_taken}, {63'd0, taken});
        check({tag, "_npc"}, pred_npc, npc);
    endtask

    initial begin
        rst_n = 1'b0; pred_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        pred_pc = 64'd0; upd_pc = 64'd0; upd_target = 64'd0;
        upd_valid = 1'b0; upd_jump = 1'b0; upd_taken = 1'b0; upd_mispred = 1'b0;

        // T1 reset
        tick(); tick();
        check("rst_valid", {63'd0, pred_valid_o}, 64'd0);
        check("rst_taken", {63'd0, pred_taken}, 64'd0);
        check("rst_npc", pred_npc, 64'd0);
        rst_n = 1'b1;
        lookup(64'h8000_0000);
        expect_pred("t1_miss", 1'b0, 64'h8000_0004);
        tick();
        check("idle_valid", {63'd0, pred_valid_o}, 64'd0);
        check("idle_npc_hold", pred_npc, 64'h8000_0004);

        // T2 allocate taken branch at WT
        update(64'h8000_0010, 1'b0, 1'b1, 64'h8000_0100);
        lookup(64'h8000_0010);
        expect_pred("t2_alloc", 1'b1, 64'h8000_0100);

        // T3 saturation walk: WT->WNT->SNT->SNT->WNT->WT->ST->ST->WT
        update(64'h8000_0010, 1'b0, 1'b0, 64'h8000_0100);
        lookup(64'h8000_0010); expect_pred("t3_wnt", 1'b0, 64'h8000_0014);
        update(64'h8000_0010, 1'b0, 1'b0, 64'h8000_0100);
        lookup(64'h8000_0010); expect_pred("t3_snt", 1'b0, 64'h8000_0014);
        update(64'h8000_0010, 1'b0, 1'b0, 64'h8000_0100);
        lookup(64'h8000_0010); expect_pred("t3_snt_sat", 1'b0, 64'h8000_0014);
        update(64'h8000_0010, 1'b0, 1'b1, 64'h8000_0100);
        lookup(64'h8000_0010); expect_pred("t3_up_wnt", 1'b0, 64'h8000_0014);
        update(64'h8000_0010, 1'b0, 1'b1, 64'h8000_0100);
        lookup(64'h8000_0010); expect_pred("t3_up_wt", 1'b1, 64'h8000_0100);
        update(64'h8000_0010, 1'b0, 1'b1, 64'h8000_0100);
        lookup(64'h8000_0010); expect_pred("t3_up_st", 1'b1, 64'h8000_0100);
        update(64'h8000_0010, 1'b0, 1'b1, 64'h8000_0100);
        lookup(64'h8000_0010); expect_pred("t3_st_sat", 1'b1, 64'h8000_0100);
        update(64'h8000_0010, 1'b0, 1'b0, 64'h8000_0100);
        lookup(64'h8000_0010); expect_pred("t3_st_dec", 1'b1, 64'h8000_0100);

        // T4 aliasing: same idx 4, tags 0 vs 1
        lookup(64'h8000_0050); expect_pred("t4_alias_miss", 1'b0, 64'h8000_0054);
        update(64'h8000_0050, 1'b1, 1'b1, 64'h8000_0200);
        lookup(64'h8000_0050); expect_pred("t4_alloc_jmp", 1'b1, 64'h8000_0200);
        lookup(64'h8000_0010); expect_pred("t4_evicted", 1'b0, 64'h8000_0014);
        update(64'h8000_0020, 1'b0, 1'b0, 64'h8000_0400);
        lookup(64'h8000_0020); expect_pred("t4_nt_nowrite", 1'b0, 64'h8000_0024);

        // T5 same-cycle lookup/update collision
        pred_valid = 1'b1; pred_pc = 64'h8000_0050;
        update(64'h8000_0050, 1'b1, 1'b1, 64'h8000_0300);
        pred_valid = 1'b0;
        expect_pred("t5_old", 1'b1, 64'h8000_0200);
        lookup(64'h8000_0050); expect_pred("t5_new", 1'b1, 64'h8000_0300);

        // T6 stall holds, flush beats stall
        stall = 1'b1; pred_valid = 1'b1; pred_pc = 64'h8000_0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_pred("t6_stall", 1'b1, 64'h8000_0300);
        end
        flush = 1'b1;
        tick();
        check("t6_flush_valid", {63'd0, pred_valid_o}, 64'd0);
        check("t6_flush_npc_hold", pred_npc, 64'h8000_0300);
        stall = 1'b0; flush = 1'b0; pred_valid = 1'b0;

        // Reset mid-operation drops in-flight lookup and clears table
        rst_n = 1'b0; pred_valid = 1'b1; pred_pc = 64'h8000_0050;
        tick();
        check("mid_rst_valid", {63'd0, pred_valid_o}, 64'd0);
        check("mid_rst_npc", pred_npc, 64'd0);
        rst_n = 1'b1;
        lookup(64'h8000_0050); expect_pred("mid_rst_cleared", 1'b0, 64'h8000_0054);

        // Statistics scenario: 10 lookups (incl. the one above), 4 hits
        upd_mispred = 1'b1;
        update(64'h8000_0030, 1'b0, 1'b1, 64'h8000_0800);
        upd_mispred = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lookup(64'h8000_0030);
            expect_pred("stat_hit_lkp", 1'b1, 64'h8000_0800);
        end
        for (int i = 0; i < 5; i++) begin
            lookup(64'h8000_1000 + 64'(i) * 64'h4);
        end
        expect_pred("stat_last_miss", 1'b0, 64'h8000_1014);
`ifdef YSYX_22050710_BPU_STATS_EN
        check("stat_lookup", {32'd0, stat_lookup}, 64'd10);
        check("stat_hit", {32'd0, stat_hit}, 64'd4);
        check("stat_upd", {32'd0, stat_upd}, 64'd1);
        check("stat_mispred", {32'd0, stat_mispred}, 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
